isqrt_pipe_arbiter: RTL and testbench

Shares one fully pipelined, fixed-latency `isqrt` instance between `N_CLIENTS` independent requesters, for example several formula FSMs. It grants one request per cycle using round-robin arbitration and drives the `isqrt` input port. A tag pipeline, aligned with the `isqrt` latency, records the owner of each issued operand so that every result is returned to the correct client. It sits between the clients and the single `isqrt` instance inside a top-level wrapper.

---
 rtl/isqrt_arb_pkg.sv | 18 +
 rtl/isqrt_arb_rr.sv | 31 +++
 rtl/isqrt_pipe_arbiter.sv | 113 +++++++++++
 tb/tb_isqrt_pipe_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isqrt_arb_pkg.sv
// Shared constants and types for the isqrt round-robin sharing block.
// The tag id field is sized for the largest supported client count.
package isqrt_arb_pkg;

    localparam int X_W      = 32;
    localparam int Y_W      = 16;
    localparam int ID_W_MAX = 8;

    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                vld;
        logic [ID_W_MAX-1:0] id;
    } tag_t;

endpackage

// File: rtl/isqrt_arb_rr.sv
// Combinational round-robin arbiter.
// The search starts one past the last winner and wraps; gnt is one-hot or zero.
module isqrt_arb_rr #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id
);

    always_comb begin
        int   idx;
        logic found;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(last) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx[ID_W-1:0]]) begin
                found                 = 1'b1;
                gnt[idx[ID_W-1:0]]    = 1'b1;
                gnt_id                = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/isqrt_pipe_arbiter.sv
// Shares one fixed-latency isqrt pipeline between N_CLIENTS requesters and
// routes each result back to its owner through a latency-matched tag pipeline.
module isqrt_pipe_arbiter
    import isqrt_arb_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int LATENCY   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_CLIENTS-1:0]           req_vld,
    input  logic [N_CLIENTS-1:0][X_W-1:0]  req_x,
    output logic [N_CLIENTS-1:0]           req_rdy,
    output logic [N_CLIENTS-1:0]           rsp_vld,
    output logic [Y_W-1:0]                 rsp_y,
    output logic                           isqrt_x_vld,
    output logic [X_W-1:0]                 isqrt_x,
    input  logic                           isqrt_y_vld,
    input  logic [Y_W-1:0]                 isqrt_y,
    output logic                           busy,
    output logic                           err
);

    localparam int ID_W = id_width(N_CLIENTS);

    // Handshake: a request transfers in the cycle req_vld[i] & req_rdy[i];
    // the client holds req_vld/req_x until then. Responses have no ready and
    // must be taken in the single cycle rsp_vld is high.
    logic [N_CLIENTS-1:0] req_masked;
    logic [N_CLIENTS-1:0] gnt;
    logic [ID_W-1:0]      gnt_id;
    logic [ID_W-1:0]      last_q, last_d;

    assign req_masked = rst ? '0 : req_vld;

    isqrt_arb_rr #(
        .N    (N_CLIENTS),
        .ID_W (ID_W)
    ) u_rr (
        .req    (req_masked),
        .last   (last_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_rdy     = gnt;
    assign isqrt_x_vld = |gnt;
    assign isqrt_x     = isqrt_x_vld ? req_x[gnt_id] : '0;

    assign last_d = isqrt_x_vld ? gnt_id : last_q;

    always_ff @(posedge clk) begin
        if (rst) last_q <= ID_W'(N_CLIENTS - 1);
        else     last_q <= last_d;
    end

    // Stage LATENCY-1 lines up with the isqrt output in the same cycle.
    tag_t tag_q [LATENCY];
    tag_t tag_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= {isqrt_x_vld, ID_W_MAX'(gnt_id)};
            for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign tag_out = tag_q[LATENCY-1];

    logic                 fire;
    logic [N_CLIENTS-1:0] rsp_vld_q, rsp_vld_d;
    logic [Y_W-1:0]       rsp_y_q, rsp_y_d;
    logic                 err_q, err_d;

    assign fire = isqrt_y_vld & tag_out.vld;

    always_comb begin
        rsp_vld_d = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            rsp_vld_d[i] = fire && (tag_out.id == ID_W_MAX'(i));
        end
        rsp_y_d = fire ? isqrt_y : rsp_y_q;
        // Orphan result or lost result: the isqrt pipe and the tags disagree.
        err_d   = err_q | (isqrt_y_vld ^ tag_out.vld);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld_q <= '0;
            rsp_y_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            rsp_vld_q <= rsp_vld_d;
            rsp_y_q   <= rsp_y_d;
            err_q     <= err_d;
        end
    end

    logic tag_any;

    always_comb begin
        tag_any = 1'b0;
        for (int i = 0; i < LATENCY; i++) tag_any = tag_any | tag_q[i].vld;
    end

    assign rsp_vld = rsp_vld_q;
    assign rsp_y   = rsp_y_q;
    assign err     = err_q;
    assign busy    = tag_any | (|rsp_vld_q) | isqrt_x_vld;

endmodule

// File: tb/tb_isqrt_pipe_arbiter.sv
// Bench for isqrt_pipe_arbiter: a behavioural isqrt pipe, a cycle monitor with
// an expected-response queue, directed sequences and a randomized phase.
module tb_isqrt_pipe_arbiter;

    localparam int N = 4;
    localparam int L = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]        cl_vld;
    logic [N-1:0][31:0]  cl_x;
    logic [N-1:0]        req_rdy, rsp_vld;
    logic [15:0]         rsp_y;
    logic                isqrt_x_vld, isqrt_y_vld, busy, err;
    logic [31:0]         isqrt_x;
    logic [15:0]         isqrt_y;
    logic                inj;

    isqrt_pipe_arbiter #(.N_CLIENTS(N), .LATENCY(L)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_vld     (cl_vld),
        .req_x       (cl_x),
        .req_rdy     (req_rdy),
        .rsp_vld     (rsp_vld),
        .rsp_y       (rsp_y),
        .isqrt_x_vld (isqrt_x_vld),
        .isqrt_x     (isqrt_x),
        .isqrt_y_vld (isqrt_y_vld),
        .isqrt_y     (isqrt_y),
        .busy        (busy),
        .err         (err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    function automatic logic [15:0] ref_isqrt(input logic [31:0] x);
        longint lo, hi, mid;
        lo = 0;
        hi = 65535;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= longint'(x)) lo = mid;
            else hi = mid - 1;
        end
        return lo[15:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- clock / reset helpers ----------------
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // ---------------- behavioural isqrt pipe ----------------
    logic [L-1:0] p_vld;
    logic [15:0]  p_y [L];

    always @(posedge clk) begin
        if (rst) begin
            p_vld <= '0;
        end else begin
            p_vld   <= {p_vld[L-2:0], isqrt_x_vld};
            p_y[0]  <= ref_isqrt(isqrt_x);
            for (int i = 1; i < L; i++) p_y[i] <= p_y[i-1];
        end
    end

    assign isqrt_y_vld = p_vld[L-1] | inj;
    assign isqrt_y     = p_y[L-1];

    // ---------------- monitor / scoreboard ----------------
    typedef struct {
        int          due;
        int          id;
        logic [15:0] y;
    } exp_t;

    exp_t exp_q[$];
    int   m_last = N - 1;
    int   m_gid  = -1;
    logic m_err  = 1'b0;

    initial begin
        forever begin
            int          gid;
            logic [N-1:0] egnt, ersp;
            logic [31:0] ex;
            exp_t        e;
            @(negedge clk);
            gid = -1;
            if (rst !== 1'b1) begin
                for (int k = 1; k <= N; k++) begin
                    int i;
                    i = (m_last + k) % N;
                    if (gid < 0 && cl_vld[i]) gid = i;
                end
            end
            egnt = '0;
            ex   = '0;
            if (gid >= 0) begin
                egnt[gid] = 1'b1;
                ex        = cl_x[gid];
            end
            chk("mon req_rdy", req_rdy, egnt);
            chk("mon isqrt_x_vld", isqrt_x_vld, gid >= 0);
            chk("mon isqrt_x", isqrt_x, ex);
            chk("mon busy", busy, (gid >= 0) || (exp_q.size() > 0));
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e    = exp_q.pop_front();
                ersp = '0;
                ersp[e.id] = 1'b1;
                chk("mon rsp_vld", rsp_vld, ersp);
                chk("mon rsp_y", rsp_y, e.y);
            end else begin
                chk("mon rsp_vld idle", rsp_vld, '0);
            end
            chk("mon err", err, m_err);
            m_gid = gid;
            if (gid >= 0) begin
                exp_q.push_back('{due: cyc + L + 1, id: gid, y: ref_isqrt(cl_x[gid])});
                m_last = gid;
            end
            if (rst) begin
                exp_q.delete();
                m_last = N - 1;
                m_err  = 1'b0;
            end else if (inj) begin
                m_err = 1'b1;
            end
        end
    end

    // ---------------- directed sequences ----------------
    typedef struct {
        int          cl;
        logic [31:0] x;
        logic [15:0] y;
    } vec_t;

    vec_t tbl [8];

    task automatic single_req(input int c, input logic [31:0] x, input logic [15:0] y);
        step();
        cl_vld[c] = 1'b1;
        cl_x[c]   = x;
        @(negedge clk);
        chk("single req_rdy", req_rdy, 64'(1) << c);
        chk("single isqrt_x", isqrt_x, x);
        step();
        cl_vld[c] = 1'b0;
        repeat (L) @(posedge clk);
        @(negedge clk);
        chk("single rsp_vld", rsp_vld, 64'(1) << c);
        chk("single rsp_y", rsp_y, y);
        step();
        @(negedge clk);
        chk("single busy drops", busy, 0);
        chk("single rsp_y holds", rsp_y, y);
    endtask

    function automatic logic [31:0] pick_x();
        logic [31:0] r;
        case ($urandom_range(0, 2))
            0:       pick_x = $urandom;
            1:       begin r = $urandom_range(0, 65535); pick_x = r * r; end
            default: pick_x = $urandom_range(0, 300);
        endcase
    endfunction

    task automatic rand_drive();
        for (int i = 0; i < N; i++) begin
            if (cl_vld[i] && m_gid == i) cl_vld[i] = 1'b0;
            if (!cl_vld[i] && $urandom_range(0, 2) != 0) begin
                cl_vld[i] = 1'b1;
                cl_x[i]   = pick_x();
            end
        end
    endtask

    int gseq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        rst    = 1'b1;
        cl_vld = '0;
        cl_x   = '0;
        inj    = 1'b0;

        tbl[0] = '{cl: 2, x: 32'd144,        y: 16'd12};
        tbl[1] = '{cl: 0, x: 32'd0,          y: 16'd0};
        tbl[2] = '{cl: 1, x: 32'd1,          y: 16'd1};
        tbl[3] = '{cl: 3, x: 32'd15,         y: 16'd3};
        tbl[4] = '{cl: 0, x: 32'd16,         y: 16'd4};
        tbl[5] = '{cl: 1, x: 32'hFFFF_FFFF,  y: 16'hFFFF};
        tbl[6] = '{cl: 2, x: 32'd99,         y: 16'd9};
        tbl[7] = '{cl: 3, x: 32'd65536,      y: 16'd256};

        repeat (2) step();
        @(negedge clk);
        chk("reset rsp_y", rsp_y, 0);
        chk("reset busy", busy, 0);
        chk("reset err", err, 0);
        step();
        rst = 1'b0;

        foreach (tbl[i]) single_req(tbl[i].cl, tbl[i].x, tbl[i].y);

        // full contention: grants 0,1,2,3,... and y = 1,2,3,4 per client
        do_reset();
        cl_x   = {32'd16, 32'd9, 32'd4, 32'd1};
        cl_vld = '1;
        for (int k = 0; k < L + 9; k++) begin
            @(negedge clk);
            if (k < 8) chk("contention grant", req_rdy, 64'(1) << gseq[k]);
            if (k >= L + 1 && k < L + 9) begin
                chk("contention rsp_vld", rsp_vld, 64'(1) << ((k - L - 1) % 4));
                chk("contention rsp_y", rsp_y, (k - L - 1) % 4 + 1);
            end
            step();
            if (k == 7) cl_vld = '0;
        end

        // priority rotation: after client 1, client 3 beats client 0
        do_reset();
        cl_x   = {32'd49, 32'd36, 32'd25, 32'd9};
        cl_vld = 4'b0010;
        @(negedge clk);
        chk("rotate first", req_rdy, 4'b0010);
        step();
        cl_vld = 4'b1001;
        @(negedge clk);
        chk("rotate 3 before 0", req_rdy, 4'b1000);
        step();
        cl_vld[3] = 1'b0;
        @(negedge clk);
        chk("rotate then 0", req_rdy, 4'b0001);
        step();
        cl_vld = '0;
        repeat (L + 3) step();

        // single client streaming every cycle
        for (int k = 0; k < 16 + L + 1; k++) begin
            if (k < 16) begin
                cl_vld[0] = 1'b1;
                cl_x[0]   = k * k;
            end else begin
                cl_vld[0] = 1'b0;
            end
            @(negedge clk);
            if (k < 16) chk("stream grant", req_rdy, 4'b0001);
            if (k >= L + 1) begin
                chk("stream rsp_vld", rsp_vld, 4'b0001);
                chk("stream rsp_y", rsp_y, k - L - 1);
            end
            step();
        end
        repeat (L + 3) step();

        // orphan result injection
        inj = 1'b1;
        step();
        inj = 1'b0;
        @(negedge clk);
        chk("orphan err set", err, 1);
        chk("orphan no rsp", rsp_vld, 0);
        repeat (3) step();
        @(negedge clk);
        chk("orphan err sticky", err, 1);
        do_reset();
        @(negedge clk);
        chk("orphan err cleared", err, 0);

        // reset while three operations are in flight
        step();
        cl_vld[1] = 1'b1;
        cl_x[1]   = 32'd100;
        step();
        cl_x[1]   = 32'd200;
        step();
        cl_x[1]   = 32'd300;
        step();
        cl_vld = '0;
        rst    = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < L + 3; k++) begin
            @(negedge clk);
            chk("midreset rsp_vld", rsp_vld, 0);
            chk("midreset busy", busy, 0);
            chk("midreset err", err, 0);
            step();
        end
        single_req(3, 32'd81, 16'd9);

        // randomized traffic against the monitor
        for (int n = 0; n < 1500; n++) begin
            step();
            rand_drive();
        end
        cl_vld = '0;
        repeat (L + 4) step();
        @(negedge clk);
        chk("drain busy", busy, 0);
        chk("drain queue empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
